// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory.
// Accepts a byte stream (header, big-endian payload words, XOR checksum)
// over valid/ready and writes each word to consecutive word addresses from 0.
// The CPU is held in reset (o_cpu_hold) until a load ends with a good checksum.
//
// Latency: one cycle per accepted byte plus one WRITE cycle per word, so at
//   least 5 cycles per word. o_wr_en rises the cycle after the 4th byte of a
//   word is accepted.
// Backpressure: o_in_ready is low in IDLE/DONE/ERR and during the WRITE cycle.
//   A stalled source (i_in_valid low) leaves the partial word untouched, with
//   no timeout.
//
// Ports:
//   i_clk, i_rst     rising-edge clock, asynchronous active-high reset
//   i_start          one-cycle pulse that starts a load (ignored while busy)
//   i_in_valid       source byte handshake: valid
//   i_in_data        source byte
//   o_in_ready       source byte handshake: ready
//   o_wr_en          memory write strobe, one cycle per word
//   o_wr_addr        word address for the write
//   o_wr_data        assembled word
//   o_busy           load in progress
//   o_done           sticky: last load succeeded
//   o_error          sticky: last load had a checksum mismatch
//   o_cpu_hold       CPU reset request
//   o_word_count     words written in the current/last load
module imem_loader #(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 32,
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_in_valid,
  input  logic [7:0]        i_in_data,
  output logic              o_in_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic              o_cpu_hold,
  output logic [ADDR_W:0]   o_word_count
);

  // Word count needs one extra bit so a full 256-word load reads back as 256.
  localparam int CW = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAYLOAD,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t              r_state;
  logic [7:0]          r_hdr;    // word total minus one
  logic [DATA_W-1:0]   r_word;   // partial word, newest byte in the LSBs
  logic [7:0]          r_acc;    // running XOR of payload bytes
  logic [1:0]          r_idx;    // byte position within the current word

  logic                w_accept;
  logic [DATA_W-1:0]   w_word_next;
  logic [CW-1:0]       w_next_count;
  logic [CW-1:0]       w_total;
  logic [ADDR_W-1:0]   w_next_addr;

  assign w_accept     = i_in_valid && o_in_ready;
  assign w_word_next  = {r_word[DATA_W-9:0], i_in_data};
  assign w_next_count = o_word_count + {{(CW-1){1'b0}}, 1'b1};
  // Header H encodes H+1 words, so 0xFF means 256 words.
  assign w_total      = {{(CW-8){1'b0}}, r_hdr} + {{(CW-1){1'b0}}, 1'b1};
  // Natural wrap: the address after the 256th word returns to 0.
  assign w_next_addr  = o_wr_addr + {{(ADDR_W-1){1'b0}}, 1'b1};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_hdr        <= '0;
      r_word       <= '0;
      r_acc        <= '0;
      r_idx        <= '0;
      o_in_ready   <= 1'b0;
      o_wr_en      <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_data    <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
      o_cpu_hold   <= HOLD_AT_RESET;
      o_word_count <= '0;
    end else begin
      case (r_state)
        // Idle and both terminal states behave the same way on start: the
        // sticky flags are only cleared when a new load begins.
        S_IDLE, S_DONE, S_ERR: begin
          if (i_start) begin
            r_state      <= S_HDR;
            r_acc        <= '0;
            r_idx        <= '0;
            o_in_ready   <= 1'b1;
            o_wr_addr    <= '0;
            o_busy       <= 1'b1;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
            o_cpu_hold   <= 1'b1;
            o_word_count <= '0;
          end
        end

        S_HDR: begin
          if (w_accept) begin
            r_hdr   <= i_in_data;
            r_state <= S_PAYLOAD;
          end
        end

        S_PAYLOAD: begin
          if (w_accept) begin
            r_word <= w_word_next;
            r_acc  <= r_acc ^ i_in_data;
            r_idx  <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              // Present the finished word for exactly one cycle; ready drops
              // so no byte can slip in during the write.
              o_wr_data  <= w_word_next;
              o_wr_en    <= 1'b1;
              o_in_ready <= 1'b0;
              r_state    <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          o_wr_en      <= 1'b0;
          o_in_ready   <= 1'b1;
          o_word_count <= w_next_count;
          o_wr_addr    <= w_next_addr;
          if (w_next_count == w_total) begin
            r_state <= S_CHK;
          end else begin
            r_state <= S_PAYLOAD;
          end
        end

        // Start is deliberately not looked at here, so a start pulse that
        // lands on the checksum cycle is dropped.
        S_CHK: begin
          if (w_accept) begin
            o_in_ready <= 1'b0;
            o_busy     <= 1'b0;
            if (i_in_data == r_acc) begin
              o_done     <= 1'b1;
              o_cpu_hold <= 1'b0;
              r_state    <= S_DONE;
            end else begin
              // Words already written stay in memory; the flag reports it.
              o_error <= 1'b1;
              r_state <= S_ERR;
            end
          end
        end

        default: begin
          r_state    <= S_IDLE;
          o_in_ready <= 1'b0;
          o_wr_en    <= 1'b0;
        end
      endcase
    end
  end

endmodule
